// File: rtl/arith_pkg.sv
// ---------------------------------------------------------------------------
// arith_pkg
// Shared definitions for the arithmetic/display chain.
//   state_t        : two-state sequencer encoding (IDLE, WORK)
//   BCD_ADJ_THRESH : digit value at or above which the double-dabble adjust
//                    is applied before a shift
//   BCD_ADJ_ADD    : amount added by that adjust
//   cnt_width()    : width of a counter that must hold the value WIDTH
// ---------------------------------------------------------------------------
package arith_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    WORK = 1'b1
  } state_t;

  localparam logic [3:0] BCD_ADJ_THRESH = 4'd5;
  localparam logic [3:0] BCD_ADJ_ADD    = 4'd3;

  // Counter must represent WIDTH itself (loaded at start), hence WIDTH+1.
  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// ---------------------------------------------------------------------------
// bcd_digit_adj
// Combinational double-dabble digit adjust: a BCD digit of 5 or more gets 3
// added so that the following left shift carries correctly into the next
// decimal digit.
//   i_digit : 4-bit BCD digit before adjust
//   o_digit : 4-bit adjusted digit (never exceeds 4'hC for valid BCD input)
// ---------------------------------------------------------------------------
module bcd_digit_adj
  import arith_pkg::*;
(
  input  logic [3:0] i_digit,
  output logic [3:0] o_digit
);

  assign o_digit = (i_digit >= BCD_ADJ_THRESH) ? (i_digit + BCD_ADJ_ADD) : i_digit;

endmodule

// File: rtl/bin2bcd_seq.sv
// ---------------------------------------------------------------------------
// bin2bcd_seq
// Sequential binary-to-BCD converter (shift-and-add-3), one input bit per
// clock. A conversion takes WIDTH cycles of busy; the result register only
// changes at completion, so intermediate accumulator values are never seen.
//   clk_i   : clock, rising edge
//   rst_i   : asynchronous active-high reset
//   start_i : conversion request, sampled only while idle
//   x_bi    : binary operand, sampled in the start cycle
//   busy_o  : high while a conversion is running (decoded from state)
//   done_o  : one-cycle pulse when y_bo takes a new result
//   y_bo    : packed BCD result, digit 0 in bits [3:0]
// ---------------------------------------------------------------------------
module bin2bcd_seq
  import arith_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  start_i,
  input  logic [WIDTH-1:0]      x_bi,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [4*DIGITS-1:0]   y_bo
);

  localparam int CW = cnt_width(WIDTH);
  localparam int BW = 4 * DIGITS;

  // Refuse to build a converter whose digits cannot hold the largest input.
  if (10 ** DIGITS <= 2 ** WIDTH - 1) begin : g_bad_digits
    $error("bin2bcd_seq: DIGITS too small for WIDTH");
  end

  state_t            r_state;
  state_t            w_state_next;
  logic [CW-1:0]     r_cnt;
  logic [WIDTH-1:0]  r_shift;
  logic [BW-1:0]     r_acc;
  logic [BW-1:0]     r_y;
  logic              r_done;

  logic [BW-1:0]        w_adj;
  logic [BW+WIDTH-1:0]  w_cat_shl;
  logic                 w_load;
  logic                 w_step;
  logic                 w_last;

  // All digits adjusted in parallel before the shift, so no adjusted digit
  // can spill into its neighbour.
  for (genvar gi = 0; gi < DIGITS; gi++) begin : g_adj
    bcd_digit_adj u_adj (
      .i_digit (r_acc[4*gi +: 4]),
      .o_digit (w_adj[4*gi +: 4])
    );
  end

  // One shift of {accumulator, shift register}; the MSB of the operand
  // enters bit 0 of the accumulator.
  assign w_cat_shl = {w_adj, r_shift} << 1;

  // Counter value 1 means this shift is the last one.
  assign w_last = (r_cnt == CW'(1));

  always_comb begin
    w_state_next = r_state;
    w_load       = 1'b0;
    w_step       = 1'b0;
    case (r_state)
      IDLE: begin
        if (start_i) begin
          w_load       = 1'b1;
          w_state_next = WORK;
        end
      end
      WORK: begin
        w_step = 1'b1;
        if (w_last) begin
          w_state_next = IDLE;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_cnt   <= '0;
      r_shift <= '0;
      r_acc   <= '0;
      r_y     <= '0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (w_load) begin
        r_shift <= x_bi;
        r_acc   <= '0;
        r_cnt   <= CW'(WIDTH);
      end else if (w_step) begin
        r_acc   <= w_cat_shl[BW+WIDTH-1:WIDTH];
        r_shift <= w_cat_shl[WIDTH-1:0];
        r_cnt   <= r_cnt - CW'(1);
        if (w_last) begin
          r_y    <= w_cat_shl[BW+WIDTH-1:WIDTH];
          r_done <= 1'b1;
        end
      end
    end
  end

  assign busy_o = (r_state == WORK);
  assign done_o = r_done;
  assign y_bo   = r_y;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// ---------------------------------------------------------------------------
// tb_bin2bcd_seq
// Directed and randomized checks of bin2bcd_seq against a decimal-digit
// reference computed with plain division/modulo.
// ---------------------------------------------------------------------------
module tb_bin2bcd_seq;

  localparam int WIDTH  = 8;
  localparam int DIGITS = 3;
  localparam int YW     = 4 * DIGITS;

  logic             clk   = 1'b0;
  logic             rst   = 1'b1;
  logic             start = 1'b0;
  logic [WIDTH-1:0] x     = '0;
  logic             busy;
  logic             done;
  logic [YW-1:0]    y;

  int checks = 0;
  int errors = 0;
  logic [YW-1:0] last_y = '0;

  bin2bcd_seq #(.WIDTH(WIDTH), .DIGITS(DIGITS)) dut (
    .clk_i   (clk),
    .rst_i   (rst),
    .start_i (start),
    .x_bi    (x),
    .busy_o  (busy),
    .done_o  (done),
    .y_bo    (y)
  );

  always #5 clk = ~clk;

  function automatic logic [YW-1:0] ref_bcd(input int v);
    logic [YW-1:0] r;
    int rem;
    r   = '0;
    rem = v;
    for (int d = 0; d < DIGITS; d++) begin
      r[4*d +: 4] = 4'(rem % 10);
      rem = rem / 10;
    end
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full conversion; optionally scribbles on x/start while busy.
  task automatic run_conv(input logic [WIDTH-1:0] v, input bit scribble);
    int n;
    logic [YW-1:0] exp_y;
    exp_y = ref_bcd(int'(v));
    start = 1'b1;
    x     = v;
    tick();
    start = 1'b0;
    chk("busy_rise", 32'(busy), 32'd1);
    chk("done_idle", 32'(done), 32'd0);
    n = 0;
    while (done !== 1'b1 && n < 20) begin
      chk("busy_hold", 32'(busy), 32'd1);
      chk("y_hold", 32'(y), 32'(last_y));
      if (scribble) begin
        x     = WIDTH'($urandom);
        start = 1'($urandom);
      end
      tick();
      n++;
    end
    start = 1'b0;
    chk("latency", 32'(n), 32'(WIDTH));
    chk("result", 32'(y), 32'(exp_y));
    chk("busy_fall", 32'(busy), 32'd0);
    last_y = exp_y;
    tick();
    chk("done_pulse", 32'(done), 32'd0);
    chk("busy_after", 32'(busy), 32'd0);
    $display("conv x=%0d y=%03h n=%0d", v, y, n);
  endtask

  initial begin
    int n;
    int since;
    int pulses;

    // Reset state
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_y", 32'(y), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    tick();
    chk("idle_busy", 32'(busy), 32'd0);

    // Directed values
    run_conv(8'd0,   1'b0);
    run_conv(8'd255, 1'b0);
    run_conv(8'd99,  1'b0);
    run_conv(8'd100, 1'b0);
    run_conv(8'd5,   1'b0);

    // Restart attempt and operand change at busy cycle 3 are ignored
    start = 1'b1;
    x     = 8'd200;
    tick();
    start = 1'b0;
    tick();
    tick();
    start = 1'b1;
    x     = 8'd17;
    tick();
    start = 1'b0;
    n = 3;
    while (done !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    chk("ign_latency", 32'(n), 32'd8);
    chk("ign_result", 32'(y), 32'h200);
    last_y = 12'h200;
    n = 0;
    for (int c = 0; c < 10; c++) begin
      tick();
      if (done === 1'b1 || busy === 1'b1) n++;
    end
    chk("ign_no_restart", 32'(n), 32'd0);
    $display("ignore-start test y=%03h", y);

    // Asynchronous reset in busy cycle 4
    start = 1'b1;
    x     = 8'd123;
    tick();
    start = 1'b0;
    tick();
    tick();
    tick();
    #2;
    rst = 1'b1;
    #1;
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_done", 32'(done), 32'd0);
    chk("mid_rst_y", 32'(y), 32'd0);
    tick();
    tick();
    rst = 1'b0;
    tick();
    chk("post_rst_busy", 32'(busy), 32'd0);
    chk("post_rst_y", 32'(y), 32'd0);
    last_y = '0;
    $display("mid-conversion reset y=%03h", y);
    run_conv(8'd42, 1'b0);

    // start held high: back-to-back every WIDTH+1 cycles
    start  = 1'b1;
    x      = 8'd64;
    since  = 0;
    pulses = 0;
    for (int c = 0; c < 40; c++) begin
      tick();
      since++;
      if (done === 1'b1) begin
        if (pulses > 0) chk("b2b_period", 32'(since), 32'(WIDTH + 1));
        pulses++;
        since = 0;
      end
      if (pulses > 0) chk("b2b_y", 32'(y), 32'h064);
      else            chk("b2b_y_pre", 32'(y), 32'(last_y));
    end
    chk("b2b_pulses", 32'(pulses), 32'd4);
    start = 1'b0;
    n = 0;
    while (busy === 1'b1 && n < 20) begin
      tick();
      n++;
    end
    chk("b2b_drain", 32'(busy), 32'd0);
    chk("b2b_final_y", 32'(y), 32'h064);
    last_y = 12'h064;
    tick();
    $display("back-to-back pulses=%0d y=%03h", pulses, y);

    // Exhaustive sweep with scribbled inputs during busy
    for (int v = 0; v < 256; v++) begin
      run_conv(WIDTH'(v), 1'b1);
    end

    // Random operands
    for (int i = 0; i < 30; i++) begin
      run_conv(WIDTH'($urandom_range(0, 255)), 1'b1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
